vga_scan_timing: RTL and testbench

//  Upstream/downstream neighbour of the room map blocks. Generates 640x480@60 VGA

---
 rtl/vga_scan_timing_pkg.sv | 38 +++
 rtl/vga_scan_timing_if.sv | 33 +++
 rtl/vga_pipe_delay.sv | 40 ++++
 rtl/vga_scan_timing.sv | 124 ++++++++++++
 tb/tb_vga_scan_timing.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vga_scan_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the VGA scan timing block: the default
// 640x480@60 raster geometry, counter widths, the RRRGGGBB pixel layout and
// the bundle of control signals that travels down the alignment delay line.
// No ports (package).
// ---------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HCW = 10;
    localparam int VCW = 10;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Control bits that must stay aligned with the colour pins.
    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
    } vga_ctrl_t;

endpackage

// File: rtl/vga_scan_timing_if.sv
// ---------------------------------------------------------------------------
// vga_scan_timing_if
// Bundles the room-map handshake (CurrentX/CurrentY/frame_start out, mapData
// back) together with the VGA pin group driven by the timing generator.
//   master : timing generator side (drives coordinates and pins, reads mapData)
//   slave  : room module / display side (drives mapData, reads the rest)
// ---------------------------------------------------------------------------
interface vga_scan_timing_if;

    logic [7:0] mapData;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic       frame_start;
    logic [2:0] vga_r;
    logic [2:0] vga_g;
    logic [1:0] vga_b;
    logic       hsync;
    logic       vsync;
    logic       blank;

    modport master (
        input  mapData,
        output CurrentX, CurrentY, frame_start,
        output vga_r, vga_g, vga_b, hsync, vsync, blank
    );

    modport slave (
        output mapData,
        input  CurrentX, CurrentY, frame_start,
        input  vga_r, vga_g, vga_b, hsync, vsync, blank
    );

endinterface

// File: rtl/vga_pipe_delay.sv
// ---------------------------------------------------------------------------
// vga_pipe_delay
// Fixed-depth shift register with a synchronous active-low clear that loads
// every stage with RST_VAL. Used to hold blank/hsync/vsync back until the
// room module's colour data catches up.
//   clk_i   : clock
//   rst_ni  : synchronous active-low clear
//   data_i  : value entering the line
//   data_o  : value DEPTH clocks later
// ---------------------------------------------------------------------------
module vga_pipe_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Clearing every stage means no stale sync pulse leaks out after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign data_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scan_timing.sv
// ---------------------------------------------------------------------------
// vga_scan_timing
// Raster generator for the room map blocks. Runs the horizontal/vertical
// counters, publishes the active-area coordinate one clock later, accepts the
// room module's colour byte MAP_DLY clocks after that and registers it onto
// the RRRGGGBB pins, forced to 0 outside the active area. Sync and blank are
// delayed so that counter-to-pin latency is 2+MAP_DLY for everything.
//   clk_vga : 25 MHz pixel clock
//   rst_n   : synchronous active-low reset
//   bus     : master side of vga_scan_timing_if (mapData in; CurrentX,
//             CurrentY, frame_start, vga_r/g/b, hsync, vsync, blank out)
// ---------------------------------------------------------------------------
module vga_scan_timing #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP,
    parameter int MAP_DLY  = 1,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic               clk_vga,
    input  logic               rst_n,
    vga_scan_timing_if.master  bus
);

    import vga_timing_pkg::*;

    localparam logic [HCW-1:0] H_ACT_END  = HCW'(H_ACTIVE);
    localparam logic [HCW-1:0] H_SYNC_BEG = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0] H_SYNC_END = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HCW-1:0] H_LAST     = HCW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VCW-1:0] V_ACT_END  = VCW'(V_ACTIVE);
    localparam logic [VCW-1:0] V_SYNC_BEG = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0] V_SYNC_END = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VCW-1:0] V_LAST     = VCW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    // The line holds control until mapData for the same pixel is present;
    // the final output register adds the last clock alongside the colour.
    localparam int PIPE_DEPTH = 1 + MAP_DLY;
    localparam vga_ctrl_t CTRL_IDLE = vga_ctrl_t'({1'b1, ~SYNC_POL, ~SYNC_POL});

    logic [HCW-1:0] hcnt_q, hcnt_d;
    logic [VCW-1:0] vcnt_q, vcnt_d;
    logic [9:0]     curX_q;
    logic [8:0]     curY_q;
    logic           frameStart_q;
    vga_ctrl_t      ctrlStage0, ctrlAligned, ctrl_q;
    rgb332_t        rgb_q;
    logic           act;

    // Next raster position: vcnt only moves on the hcnt wrap, and both
    // wrap together at the last pixel of the frame.
    always_comb begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
        end
    end

    // Stage-0 decode of the current counter state.
    always_comb begin
        act              = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);
        ctrlStage0.blank = ~act;
        ctrlStage0.hsync = ((hcnt_q >= H_SYNC_BEG) && (hcnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
        ctrlStage0.vsync = ((vcnt_q >= V_SYNC_BEG) && (vcnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

    // Counters and the coordinate handed to the room modules.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            curX_q       <= '0;
            curY_q       <= '0;
            frameStart_q <= 1'b0;
        end else begin
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            curX_q       <= act ? hcnt_q : '0;
            curY_q       <= act ? vcnt_q[8:0] : '0;
            frameStart_q <= (hcnt_q == '0) && (vcnt_q == '0);
        end
    end

    vga_pipe_delay #(
        .WIDTH   ($bits(vga_ctrl_t)),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL (CTRL_IDLE)
    ) u_ctrl_delay (
        .clk_i  (clk_vga),
        .rst_ni (rst_n),
        .data_i (ctrlStage0),
        .data_o (ctrlAligned)
    );

    // Pin register: colour is gated by the blank bit that belongs to the
    // same pixel, so mapData outside the active area never reaches the pins.
    always_ff @(posedge clk_vga) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_IDLE;
            rgb_q  <= '0;
        end else begin
            ctrl_q <= ctrlAligned;
            rgb_q  <= ctrlAligned.blank ? '0 : rgb332_t'(bus.mapData);
        end
    end

    assign bus.CurrentX    = curX_q;
    assign bus.CurrentY    = curY_q;
    assign bus.frame_start = frameStart_q;
    assign bus.vga_r       = rgb_q.r;
    assign bus.vga_g       = rgb_q.g;
    assign bus.vga_b       = rgb_q.b;
    assign bus.blank       = ctrl_q.blank;
    assign bus.hsync       = ctrl_q.hsync;
    assign bus.vsync       = ctrl_q.vsync;

endmodule

// File: tb/tb_vga_scan_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_timing
// Drives two copies of vga_scan_timing from one clock and reset: one with the
// full 640x480 geometry (MAP_DLY=1) and one with a shrunken raster (MAP_DLY=2)
// so several whole frames fit in a short run. A behavioural raster model turns
// "edges since reset" into the expected coordinate, sync, blank and colour,
// and emulates a room module that answers with a pixel colour for each
// coordinate.
// ---------------------------------------------------------------------------
module tb_vga_scan_timing;

    typedef struct {
        int ha, hf, hs, hb;
        int va, vf, vs, vb;
        int md;
    } timing_t;

    localparam timing_t T_FULL  = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33, md:1};
    localparam timing_t T_SMALL = '{ha:40,  hf:4,  hs:8,  hb:6,  va:20,  vf:2,  vs:2, vb:3,  md:2};

    logic clk;
    logic rst_n;

    vga_scan_timing_if busFull ();
    vga_scan_timing_if busSmall ();

    vga_scan_timing #(
        .H_ACTIVE(T_FULL.ha), .H_FP(T_FULL.hf), .H_SYNC(T_FULL.hs), .H_BP(T_FULL.hb),
        .V_ACTIVE(T_FULL.va), .V_FP(T_FULL.vf), .V_SYNC(T_FULL.vs), .V_BP(T_FULL.vb),
        .MAP_DLY(T_FULL.md), .SYNC_POL(1'b0)
    ) dutFull (
        .clk_vga (clk),
        .rst_n   (rst_n),
        .bus     (busFull)
    );

    vga_scan_timing #(
        .H_ACTIVE(T_SMALL.ha), .H_FP(T_SMALL.hf), .H_SYNC(T_SMALL.hs), .H_BP(T_SMALL.hb),
        .V_ACTIVE(T_SMALL.va), .V_FP(T_SMALL.vf), .V_SYNC(T_SMALL.vs), .V_BP(T_SMALL.vb),
        .MAP_DLY(T_SMALL.md), .SYNC_POL(1'b0)
    ) dutSmall (
        .clk_vga (clk),
        .rst_n   (rst_n),
        .bus     (busSmall)
    );

    int        checks;
    int        failures;
    int        n;
    int        lastFs;
    int        activeCnt;
    int        vsLowCnt;
    bit        aggOpen;
    bit        constMode;
    logic [7:0] lut [1024];

    initial clk = 1'b0;
    always #20 clk = ~clk;

    function automatic int hTot(timing_t t);
        return t.ha + t.hf + t.hs + t.hb;
    endfunction

    function automatic int fTot(timing_t t);
        return hTot(t) * (t.va + t.vf + t.vs + t.vb);
    endfunction

    // Counter state s (clocks since reset release) -> raster position.
    function automatic void rasterPos(timing_t t, int s, output int x, output int y);
        int p;
        p = s % fTot(t);
        x = p % hTot(t);
        y = p / hTot(t);
    endfunction

    // What a room module would return for pixel (x,y).
    function automatic logic [7:0] pixelColour(timing_t t, int x, int y);
        if (constMode) return 8'hFF;
        if (x == t.ha - 1 && y == t.va - 1) return 8'b101_010_01;
        return lut[(x * 7 + y * 13) % 1024];
    endfunction

    // mapData to present after edge n: colour of the pixel whose control bits
    // reach the pin register on the next edge, random junk elsewhere.
    function automatic logic [7:0] nextData(timing_t t, int edgeNum, bit rstEdge);
        int s, x, y;
        s = edgeNum - 1 - t.md;
        if (rstEdge || s < 0) return 8'($urandom);
        rasterPos(t, s, x, y);
        if (x < t.ha && y < t.va) return pixelColour(t, x, y);
        return 8'($urandom);
    endfunction

    // Compare one DUT against the raster model after edge edgeNum.
    task automatic checkOutput(input string tag, input timing_t t, input int edgeNum, input bit rstEdge,
                               input logic [7:0] dataSeen, input logic [19:0] obsCoord,
                               input logic [10:0] obsPins);
        int x, y, lat;
        bit act, blankE, hsE, vsE;
        logic [19:0] expCoord;
        logic [10:0] expPins;
        lat = 2 + t.md;
        if (rstEdge) begin
            expCoord = '0;
            expPins  = {3'b111, 8'h00};
        end else begin
            rasterPos(t, edgeNum - 1, x, y);
            act = (x < t.ha) && (y < t.va);
            expCoord = {act ? 10'(x) : 10'd0, act ? 9'(y) : 9'd0, ((edgeNum - 1) % fTot(t)) == 0};
            if (edgeNum - lat < 0) begin
                expPins = {3'b111, 8'h00};
            end else begin
                rasterPos(t, edgeNum - lat, x, y);
                blankE  = !((x < t.ha) && (y < t.va));
                hsE     = !((x >= t.ha + t.hf) && (x < t.ha + t.hf + t.hs));
                vsE     = !((y >= t.va + t.vf) && (y < t.va + t.vf + t.vs));
                expPins = {blankE, hsE, vsE, blankE ? 8'h00 : dataSeen};
            end
        end
        checks++;
        assert (obsCoord === expCoord) else begin
            failures++;
            $error("[TB] FAIL %s_coord n=%0d observed={x,y,fs}=%h expected=%h", tag, edgeNum, obsCoord, expCoord);
        end
        checks++;
        assert (obsPins === expPins) else begin
            failures++;
            $error("[TB] FAIL %s_pins n=%0d observed={blank,hs,vs,rgb}=%h expected=%h", tag, edgeNum, obsPins, expPins);
        end
    endtask

    // One clock: drive reset, step the model, check both DUTs, update the
    // frame-level tallies of the small raster and present the next mapData.
    task automatic applyStimulus(input bit rstVal);
        logic [7:0] seenFull, seenSmall;
        bit rstEdge;
        int latS, ftS;
        latS      = 2 + T_SMALL.md;
        ftS       = fTot(T_SMALL);
        rst_n     = rstVal;
        seenFull  = busFull.mapData;
        seenSmall = busSmall.mapData;
        @(posedge clk);
        #1;
        rstEdge = !rstVal;
        if (rstEdge) begin
            n       = 0;
            lastFs  = -1;
            aggOpen = 1'b0;
        end else begin
            n++;
        end
        checkOutput("full", T_FULL, n, rstEdge, seenFull,
                    {busFull.CurrentX, busFull.CurrentY, busFull.frame_start},
                    {busFull.blank, busFull.hsync, busFull.vsync, busFull.vga_r, busFull.vga_g, busFull.vga_b});
        checkOutput("small", T_SMALL, n, rstEdge, seenSmall,
                    {busSmall.CurrentX, busSmall.CurrentY, busSmall.frame_start},
                    {busSmall.blank, busSmall.hsync, busSmall.vsync, busSmall.vga_r, busSmall.vga_g, busSmall.vga_b});
        if (!rstEdge) begin
            if (busSmall.frame_start === 1'b1) begin
                if (lastFs >= 0) begin
                    checks++;
                    assert ((n - lastFs) === ftS) else begin
                        failures++;
                        $error("[TB] FAIL small_fs_period observed=%0d expected=%0d", n - lastFs, ftS);
                    end
                end
                lastFs = n;
            end
            if (aggOpen && n >= latS && n < latS + 2 * ftS) begin
                if (busSmall.blank === 1'b0) activeCnt++;
                if (busSmall.vsync === 1'b0) vsLowCnt++;
                if (n == latS + 2 * ftS - 1) begin
                    checks++;
                    assert (activeCnt === 2 * T_SMALL.ha * T_SMALL.va) else begin
                        failures++;
                        $error("[TB] FAIL small_active_count observed=%0d expected=%0d", activeCnt, 2 * T_SMALL.ha * T_SMALL.va);
                    end
                    checks++;
                    assert (vsLowCnt === 2 * T_SMALL.vs * hTot(T_SMALL)) else begin
                        failures++;
                        $error("[TB] FAIL small_vsync_count observed=%0d expected=%0d", vsLowCnt, 2 * T_SMALL.vs * hTot(T_SMALL));
                    end
                    aggOpen = 1'b0;
                end
            end
        end
        busFull.mapData  = nextData(T_FULL, n, rstEdge);
        busSmall.mapData = nextData(T_SMALL, n, rstEdge);
    endtask

    initial begin
        int target, ftS;
        checks    = 0;
        failures  = 0;
        n         = 0;
        lastFs    = -1;
        activeCnt = 0;
        vsLowCnt  = 0;
        aggOpen   = 1'b0;
        constMode = 1'b0;
        for (int i = 0; i < 1024; i++) lut[i] = 8'($urandom);
        ftS    = fTot(T_SMALL);
        target = (T_SMALL.va + T_SMALL.vf + 1) * hTot(T_SMALL) + (T_SMALL.ha + T_SMALL.hf + 4);
        rst_n  = 1'b0;
        busFull.mapData  = 8'($urandom);
        busSmall.mapData = 8'($urandom);

        $display("[TB] holding reset for 3 clocks");
        repeat (3) applyStimulus(1'b0);

        $display("[TB] release, free-run two small frames with random pixel colours");
        aggOpen = 1'b1;
        repeat (2 * ftS + 100) applyStimulus(1'b1);

        $display("[TB] constant mapData=FF for one frame");
        constMode = 1'b1;
        repeat (ftS) applyStimulus(1'b1);
        constMode = 1'b0;

        $display("[TB] run to mid-vsync of the small raster, then pulse reset");
        for (int k = 0; k < ftS && (n % ftS) != target; k++) applyStimulus(1'b1);
        checks++;
        assert ((n % ftS) === target) else begin
            failures++;
            $error("[TB] FAIL reach_mid_vsync observed=%0d expected=%0d", n % ftS, target);
        end
        applyStimulus(1'b0);

        $display("[TB] restart and run a full small frame past the last active pixel");
        repeat (ftS + 20) applyStimulus(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
